dfi_init_refresh: RTL and testbench
===================================

Name: dfi_init_refresh

Overview:
- Drives the two-phase DFI command/address inputs of the Spartan-6 DDR PHY.
- After reset it runs the JEDEC DDR power-up sequence, then hands the DFI command bus to the memory controller.
- While the controller owns the bus, it schedules periodic auto-refresh through a req/ack handshake.
- Sits directly upstream of the PHY's dfi_*_p0/p1 command inputs.

Parameters:
- NUM_AD, 13, SDRAM address width
- NUM_BA, 2, bank address width
- INIT_WAIT, 20000, sys_clk cycles with CKE low after reset (>=200us)
- TRP, 2, cycles from PRECHARGE to next command
- TMRD, 2, cycles from MRS/EMRS to next command
- TRFC, 8, cycles from AUTO REFRESH to next command
- TDLL, 200, cycles after final MRS before handing over
- TREFI, 780, refresh interval in cycles
- MR_VALUE, 13'h022, mode register (BL4, sequential, CL2)
- EMR_VALUE, 13'h000, extended mode register (DLL enabled)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset
- host_address_p0/p1  in  NUM_AD  controller address, per phase
- host_bank_p0/p1  in  NUM_BA  controller bank, per phase
- host_cs_n_p0/p1, host_ras_n_p0/p1, host_cas_n_p0/p1, host_we_n_p0/p1  in  1 each  controller command, per phase
- host_grant  out  1  controller owns the DFI command bus
- ref_req  out  1  refresh wanted
- ref_ack  in  1  controller has closed all banks and stopped issuing
- init_done  out  1  power-up sequence complete (sticky until reset)
- ref_missed  out  1  sticky: a refresh interval expired while a refresh was already pending
- dfi_address_p0/p1  out  NUM_AD  to PHY
- dfi_bank_p0/p1  out  NUM_BA  to PHY
- dfi_cs_n_p0/p1, dfi_cke_p0/p1, dfi_ras_n_p0/p1, dfi_cas_n_p0/p1, dfi_we_n_p0/p1  out  1 each  to PHY

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Output registering: all outputs are registered.
- Reset values:
  - cke = 0, cs_n = 1, ras_n/cas_n/we_n = 1, address = 0, bank = 0 (both phases)
  - host_grant = 0, ref_req = 0, init_done = 0, ref_missed = 0
- Reset mid-operation: sys_rst at any time returns the block to INIT_WAIT with the reset values above, including mid-sequence or mid-refresh.
- Command encoding ({cs_n,ras_n,cas_n,we_n}):
  - DESELECT = 1xxx, driven as 1111
  - NOP = 0111
  - PRECHARGE = 0010, with A10 = 1 (precharge all)
  - AUTO REFRESH = 0001
  - MRS/EMRS = 0000
- Phase use for own commands: commands generated by this block go on phase 0. Phase 1 carries NOP (DESELECT while CKE is low). cke is identical on both phases.
- Command spacing: a command issued at cycle t is followed by NOP until cycle t+T, where T is the timing parameter. A single down-counter, loaded with T-1, provides this.
- Power-up state sequence:
  - INIT_WAIT: DESELECT, cke = 0, INIT_WAIT cycles.
  - CKE_ON: cke = 1, NOP for 1 cycle.
  - PRE1: PRECHARGE, then TRP.
  - EMRS: BA = 01, A = EMR_VALUE, then TMRD.
  - MRS_DLL: BA = 00, A = MR_VALUE | 13'h100, then TMRD.
  - PRE2: PRECHARGE, then TRP.
  - AREF1: AUTO REFRESH, then TRFC.
  - AREF2: AUTO REFRESH, then TRFC.
  - MRS: BA = 00, A = MR_VALUE, then TMRD.
  - DLL_WAIT: TDLL cycles.
  - READY.
- Entering READY: init_done = 1 and host_grant = 1. The refresh counter loads TREFI-1.
- READY pass-through: dfi_* = host_* registered, 1-cycle latency. cke is forced to 1.
- Refresh counter:
  - Decrements in every state after DLL_WAIT, including during refresh.
  - At 0 it reloads TREFI-1 and sets pending.
  - Expiry while pending is already set sets ref_missed; the extra refresh is dropped.
- Refresh handshake:
  - ref_req = pending && host_grant.
  - Cycle after ref_ack is sampled high while ref_req = 1: host_grant = 0, ref_req = 0, pending cleared, state becomes REF_PRE. Host inputs are ignored from this cycle on.
  - ref_ack while ref_req = 0 is ignored.
- Refresh sequence: REF_PRE (PRECHARGE, then TRP) -> REF_AREF (AUTO REFRESH, then TRFC) -> READY. host_grant = 1 on the first cycle back in READY.
- While host_grant = 0: dfi outputs are only this block's commands or NOP.

Decomposition:
- Shared package dfi_pkg:
  - 4-bit command encodings (CMD_DESELECT, CMD_NOP, CMD_PRE, CMD_AREF, CMD_MRS)
  - state enum
  - A10 precharge-all bit index
- One sub-module, ddr_delay_counter:
  - loadable down-counter, width sized from max(INIT_WAIT, TDLL, TREFI)
  - outputs done when zero
  - two instances: command spacing and refresh interval

Test Plan (INIT_WAIT=10, TRP=2, TMRD=2, TRFC=4, TDLL=5, TREFI=40, MR_VALUE=13'h022, EMR_VALUE=13'h000):
- Release reset -> cke = 0 for 10 cycles; then PRE (A10 = 1), EMRS (BA = 1, A = 0), MRS (A = 13'h122), PRE, AREF, AREF, MRS (A = 13'h022) at spacings 2,2,2,2,4,4,2; init_done = 1 and host_grant = 1 five cycles after the last MRS; phase 1 is NOP throughout.
- READY, host drives ACTIVE on p0 and READ on p1 -> identical values on dfi p0/p1 exactly one cycle later, cke = 1.
- Refresh interval expires -> ref_req = 1; ack after 3 cycles -> next cycle host_grant = 0; PRE, then AREF 2 cycles later, then host_grant = 1 4 cycles after AREF; host commands during the gap do not appear.
- ref_ack withheld for > 40 cycles -> ref_missed = 1 and stays set; exactly one refresh performed after ack.
- ref_ack pulsed with no ref_req -> no state change.
- sys_rst asserted during AREF2 or REF_AREF -> next cycle all outputs at reset values; full sequence restarts.

Source files
------------

// File: rtl/dfi_pkg.sv
// Shared definitions for the DFI power-up / refresh sequencer: command encodings,
// sequencer states and the fixed successor of each timed state.
package dfi_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESELECT = 4'b1111;
    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_PRE      = 4'b0010;
    localparam logic [3:0] CMD_AREF     = 4'b0001;
    localparam logic [3:0] CMD_MRS      = 4'b0000;

    localparam int A10_BIT = 10;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_CKE_ON,
        ST_PRE1,
        ST_EMRS,
        ST_MRS_DLL,
        ST_PRE2,
        ST_AREF1,
        ST_AREF2,
        ST_MRS,
        ST_DLL_WAIT,
        ST_READY,
        ST_REF_PRE,
        ST_REF_AREF
    } state_e;

    // Where a timed state goes once its spacing counter has run out.
    function automatic state_e seq_next(input state_e st);
        case (st)
            ST_INIT_WAIT: seq_next = ST_CKE_ON;
            ST_CKE_ON:    seq_next = ST_PRE1;
            ST_PRE1:      seq_next = ST_EMRS;
            ST_EMRS:      seq_next = ST_MRS_DLL;
            ST_MRS_DLL:   seq_next = ST_PRE2;
            ST_PRE2:      seq_next = ST_AREF1;
            ST_AREF1:     seq_next = ST_AREF2;
            ST_AREF2:     seq_next = ST_MRS;
            ST_MRS:       seq_next = ST_DLL_WAIT;
            ST_DLL_WAIT:  seq_next = ST_READY;
            ST_READY:     seq_next = ST_READY;
            ST_REF_PRE:   seq_next = ST_REF_AREF;
            ST_REF_AREF:  seq_next = ST_READY;
            default:      seq_next = ST_INIT_WAIT;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ddr_delay_counter.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module ddr_delay_counter #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/dfi_init_refresh.sv
// DDR power-up sequencer and periodic auto-refresh scheduler sitting in front of
// the PHY's two-phase DFI command inputs; hands the bus to the controller when idle.
module dfi_init_refresh
    import dfi_pkg::*;
#(
    parameter int                 NUM_AD    = 13,
    parameter int                 NUM_BA    = 2,
    parameter int                 INIT_WAIT = 20000,
    parameter int                 TRP       = 2,
    parameter int                 TMRD      = 2,
    parameter int                 TRFC      = 8,
    parameter int                 TDLL      = 200,
    parameter int                 TREFI     = 780,
    parameter logic [NUM_AD-1:0]  MR_VALUE  = NUM_AD'('h022),
    parameter logic [NUM_AD-1:0]  EMR_VALUE = NUM_AD'('h000)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [NUM_AD-1:0] host_address_p0,
    input  logic [NUM_AD-1:0] host_address_p1,
    input  logic [NUM_BA-1:0] host_bank_p0,
    input  logic [NUM_BA-1:0] host_bank_p1,
    input  logic              host_cs_n_p0,
    input  logic              host_cs_n_p1,
    input  logic              host_ras_n_p0,
    input  logic              host_ras_n_p1,
    input  logic              host_cas_n_p0,
    input  logic              host_cas_n_p1,
    input  logic              host_we_n_p0,
    input  logic              host_we_n_p1,
    output logic              host_grant,
    output logic              ref_req,
    input  logic              ref_ack,
    output logic              init_done,
    output logic              ref_missed,
    output logic [NUM_AD-1:0] dfi_address_p0,
    output logic [NUM_AD-1:0] dfi_address_p1,
    output logic [NUM_BA-1:0] dfi_bank_p0,
    output logic [NUM_BA-1:0] dfi_bank_p1,
    output logic              dfi_cs_n_p0,
    output logic              dfi_cs_n_p1,
    output logic              dfi_cke_p0,
    output logic              dfi_cke_p1,
    output logic              dfi_ras_n_p0,
    output logic              dfi_ras_n_p1,
    output logic              dfi_cas_n_p0,
    output logic              dfi_cas_n_p1,
    output logic              dfi_we_n_p0,
    output logic              dfi_we_n_p1
);

    localparam int CNT_MAX = max3(INIT_WAIT, TDLL, TREFI);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_INIT = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] LD_TRP  = CW'(TRP - 1);
    localparam logic [CW-1:0] LD_TMRD = CW'(TMRD - 1);
    localparam logic [CW-1:0] LD_TRFC = CW'(TRFC - 1);
    // DLL lock time is measured from the final MRS, which already spent TMRD.
    localparam logic [CW-1:0] LD_DLL  = CW'(TDLL - TMRD - 1);
    localparam logic [CW-1:0] LD_REFI = CW'(TREFI - 1);

    localparam logic [NUM_AD-1:0] MR_DLL_RESET = MR_VALUE | (NUM_AD'(1) << 8);

    state_e state_d, state_q;
    logic   enter;
    logic   take;
    logic   dly_load, dly_dec, dly_done;
    logic [CW-1:0] dly_load_val;
    logic   rc_load, rc_dec, rc_done;
    logic   ref_active, expire;

    logic              cke_d, cke_q;
    logic              grant_d, grant_q;
    logic              init_done_d, init_done_q;
    logic              pending_d, pending_q;
    logic              ref_req_d, ref_req_q;
    logic              missed_d, missed_q;

    logic [3:0]        cmd_d  [2];
    logic [NUM_AD-1:0] addr_d [2];
    logic [NUM_BA-1:0] bank_d [2];

    logic [3:0]        host_cmd  [2];
    logic [NUM_AD-1:0] host_addr [2];
    logic [NUM_BA-1:0] host_bank [2];

    assign host_cmd[0]  = {host_cs_n_p0, host_ras_n_p0, host_cas_n_p0, host_we_n_p0};
    assign host_cmd[1]  = {host_cs_n_p1, host_ras_n_p1, host_cas_n_p1, host_we_n_p1};
    assign host_addr[0] = host_address_p0;
    assign host_addr[1] = host_address_p1;
    assign host_bank[0] = host_bank_p0;
    assign host_bank[1] = host_bank_p1;

    ddr_delay_counter #(.W(CW), .RESET_VAL(LD_INIT)) u_cmd_dly (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (dly_load),
        .load_val (dly_load_val),
        .dec      (dly_dec),
        .done     (dly_done)
    );

    ddr_delay_counter #(.W(CW), .RESET_VAL('0)) u_ref_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (rc_load),
        .load_val (LD_REFI),
        .dec      (rc_dec),
        .done     (rc_done)
    );

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        take    = (state_q == ST_READY) && ref_ack && ref_req_q;
        if (state_q == ST_READY) begin
            if (take) begin
                state_d = ST_REF_PRE;
                enter   = 1'b1;
            end
        end else if (dly_done) begin
            state_d = seq_next(state_q);
            enter   = 1'b1;
        end

        dly_load     = enter;
        dly_load_val = '0;
        dly_dec      = !enter && (state_q != ST_READY);
        cke_d        = 1'b1;
        grant_d      = grant_q;
        init_done_d  = init_done_q;
        for (int p = 0; p < 2; p++) begin
            cmd_d[p]  = CMD_NOP;
            addr_d[p] = '0;
            bank_d[p] = '0;
        end

        if (state_d == ST_INIT_WAIT) begin
            cke_d    = 1'b0;
            cmd_d[0] = CMD_DESELECT;
            cmd_d[1] = CMD_DESELECT;
        end

        // Own commands go out on phase 0 on the cycle a state is entered.
        if (enter) begin
            case (state_d)
                ST_INIT_WAIT: dly_load_val = LD_INIT;
                ST_PRE1, ST_PRE2, ST_REF_PRE: begin
                    cmd_d[0]           = CMD_PRE;
                    addr_d[0][A10_BIT] = 1'b1;
                    dly_load_val       = LD_TRP;
                end
                ST_EMRS: begin
                    cmd_d[0]     = CMD_MRS;
                    bank_d[0]    = NUM_BA'(1);
                    addr_d[0]    = EMR_VALUE;
                    dly_load_val = LD_TMRD;
                end
                ST_MRS_DLL: begin
                    cmd_d[0]     = CMD_MRS;
                    addr_d[0]    = MR_DLL_RESET;
                    dly_load_val = LD_TMRD;
                end
                ST_AREF1, ST_AREF2, ST_REF_AREF: begin
                    cmd_d[0]     = CMD_AREF;
                    dly_load_val = LD_TRFC;
                end
                ST_MRS: begin
                    cmd_d[0]     = CMD_MRS;
                    addr_d[0]    = MR_VALUE;
                    dly_load_val = LD_TMRD;
                end
                ST_DLL_WAIT: dly_load_val = LD_DLL;
                ST_READY: begin
                    grant_d     = 1'b1;
                    init_done_d = 1'b1;
                end
                default: dly_load_val = '0;
            endcase
            if (state_d == ST_REF_PRE) begin
                grant_d = 1'b0;
            end
        end else if (state_q == ST_READY) begin
            for (int p = 0; p < 2; p++) begin
                cmd_d[p]  = host_cmd[p];
                addr_d[p] = host_addr[p];
                bank_d[p] = host_bank[p];
            end
        end

        // Refresh interval keeps running through the refresh sequence itself.
        ref_active = (state_q == ST_READY) || (state_q == ST_REF_PRE) || (state_q == ST_REF_AREF);
        expire     = ref_active && rc_done;
        rc_load    = expire || (enter && (state_d == ST_READY) && (state_q == ST_DLL_WAIT));
        rc_dec     = ref_active && !rc_done;
        pending_d  = expire || (pending_q && !take);
        missed_d   = missed_q || (expire && pending_q && !take);
        ref_req_d  = pending_d && grant_d;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_INIT_WAIT;
            cke_q       <= 1'b0;
            grant_q     <= 1'b0;
            init_done_q <= 1'b0;
            pending_q   <= 1'b0;
            ref_req_q   <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cke_q       <= cke_d;
            grant_q     <= grant_d;
            init_done_q <= init_done_d;
            pending_q   <= pending_d;
            ref_req_q   <= ref_req_d;
            missed_q    <= missed_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_phase
        logic [3:0]        cmd_q;
        logic [NUM_AD-1:0] addr_q;
        logic [NUM_BA-1:0] bank_q;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                cmd_q  <= CMD_DESELECT;
                addr_q <= '0;
                bank_q <= '0;
            end else begin
                cmd_q  <= cmd_d[gi];
                addr_q <= addr_d[gi];
                bank_q <= bank_d[gi];
            end
        end
    end

    assign dfi_cke_p0     = cke_q;
    assign dfi_cke_p1     = cke_q;
    assign dfi_cs_n_p0    = g_phase[0].cmd_q[3];
    assign dfi_ras_n_p0   = g_phase[0].cmd_q[2];
    assign dfi_cas_n_p0   = g_phase[0].cmd_q[1];
    assign dfi_we_n_p0    = g_phase[0].cmd_q[0];
    assign dfi_address_p0 = g_phase[0].addr_q;
    assign dfi_bank_p0    = g_phase[0].bank_q;
    assign dfi_cs_n_p1    = g_phase[1].cmd_q[3];
    assign dfi_ras_n_p1   = g_phase[1].cmd_q[2];
    assign dfi_cas_n_p1   = g_phase[1].cmd_q[1];
    assign dfi_we_n_p1    = g_phase[1].cmd_q[0];
    assign dfi_address_p1 = g_phase[1].addr_q;
    assign dfi_bank_p1    = g_phase[1].bank_q;

    assign host_grant = grant_q;
    assign ref_req    = ref_req_q;
    assign init_done  = init_done_q;
    assign ref_missed = missed_q;

endmodule

// File: tb/tb_dfi_init_refresh.sv
// Directed bench: power-up timeline, host pass-through, refresh handshake,
// missed-refresh flag and reset in the middle of refresh / init sequences.
`timescale 1ns/1ps
module tb_dfi_init_refresh;

    localparam logic [3:0] C_DES  = 4'b1111;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [12:0] host_address_p0, host_address_p1;
    logic [1:0]  host_bank_p0, host_bank_p1;
    logic        host_cs_n_p0, host_cs_n_p1, host_ras_n_p0, host_ras_n_p1;
    logic        host_cas_n_p0, host_cas_n_p1, host_we_n_p0, host_we_n_p1;
    logic        ref_ack = 1'b0;
    logic        host_grant, ref_req, init_done, ref_missed;
    logic [12:0] dfi_address_p0, dfi_address_p1;
    logic [1:0]  dfi_bank_p0, dfi_bank_p1;
    logic        dfi_cs_n_p0, dfi_cs_n_p1, dfi_cke_p0, dfi_cke_p1;
    logic        dfi_ras_n_p0, dfi_ras_n_p1, dfi_cas_n_p0, dfi_cas_n_p1;
    logic        dfi_we_n_p0, dfi_we_n_p1;

    dfi_init_refresh #(
        .NUM_AD(13), .NUM_BA(2), .INIT_WAIT(10), .TRP(2), .TMRD(2), .TRFC(4),
        .TDLL(5), .TREFI(40), .MR_VALUE(13'h022), .EMR_VALUE(13'h000)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .host_address_p0(host_address_p0), .host_address_p1(host_address_p1),
        .host_bank_p0(host_bank_p0), .host_bank_p1(host_bank_p1),
        .host_cs_n_p0(host_cs_n_p0), .host_cs_n_p1(host_cs_n_p1),
        .host_ras_n_p0(host_ras_n_p0), .host_ras_n_p1(host_ras_n_p1),
        .host_cas_n_p0(host_cas_n_p0), .host_cas_n_p1(host_cas_n_p1),
        .host_we_n_p0(host_we_n_p0), .host_we_n_p1(host_we_n_p1),
        .host_grant(host_grant), .ref_req(ref_req), .ref_ack(ref_ack),
        .init_done(init_done), .ref_missed(ref_missed),
        .dfi_address_p0(dfi_address_p0), .dfi_address_p1(dfi_address_p1),
        .dfi_bank_p0(dfi_bank_p0), .dfi_bank_p1(dfi_bank_p1),
        .dfi_cs_n_p0(dfi_cs_n_p0), .dfi_cs_n_p1(dfi_cs_n_p1),
        .dfi_cke_p0(dfi_cke_p0), .dfi_cke_p1(dfi_cke_p1),
        .dfi_ras_n_p0(dfi_ras_n_p0), .dfi_ras_n_p1(dfi_ras_n_p1),
        .dfi_cas_n_p0(dfi_cas_n_p0), .dfi_cas_n_p1(dfi_cas_n_p1),
        .dfi_we_n_p0(dfi_we_n_p0), .dfi_we_n_p1(dfi_we_n_p1)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
    } init_ev_t;

    typedef struct {
        logic [3:0]  c0;
        logic [1:0]  b0;
        logic [12:0] a0;
        logic [3:0]  c1;
        logic [1:0]  b1;
        logic [12:0] a1;
        logic [47:0] exp;
    } pt_vec_t;

    init_ev_t init_tab[7];
    pt_vec_t  pt_tab[4];

    // One phase as {cke, cs_n, ras_n, cas_n, we_n, bank, address}
    function automatic logic [19:0] pw(input logic cke, input logic [3:0] cmd,
                                       input logic [1:0] ba, input logic [12:0] a);
        return {cke, cmd, ba, a};
    endfunction

    function automatic logic [47:0] ew(input logic [19:0] p0, input logic [19:0] p1,
                                       input logic [3:0] fl);
        return {p0, p1, 4'b0000, fl};
    endfunction

    // flags = {host_grant, ref_req, init_done, ref_missed}
    function automatic logic [47:0] snap();
        return {dfi_cke_p0, dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0,
                dfi_bank_p0, dfi_address_p0,
                dfi_cke_p1, dfi_cs_n_p1, dfi_ras_n_p1, dfi_cas_n_p1, dfi_we_n_p1,
                dfi_bank_p1, dfi_address_p1,
                4'b0000, host_grant, ref_req, init_done, ref_missed};
    endfunction

    function automatic logic [47:0] init_exp(input int k);
        logic [19:0] p0;
        logic [19:0] p1;
        p0 = (k < 10) ? pw(1'b0, C_DES, 2'd0, 13'h0) : pw(1'b1, C_NOP, 2'd0, 13'h0);
        p1 = p0;
        for (int i = 0; i < 7; i++) begin
            if (init_tab[i].cyc == k) p0 = pw(1'b1, init_tab[i].cmd, init_tab[i].ba, init_tab[i].a);
        end
        return ew(p0, p1, (k >= 32) ? 4'b1010 : 4'b0000);
    endfunction

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, got, exp);
        end else begin
            $display("ok   %s @cyc %0d: %h", name, cyc, got);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        cyc++;
        @(negedge sys_clk);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic host_drive(input logic [3:0] c0, input logic [1:0] b0, input logic [12:0] a0,
                              input logic [3:0] c1, input logic [1:0] b1, input logic [12:0] a1);
        {host_cs_n_p0, host_ras_n_p0, host_cas_n_p0, host_we_n_p0} = c0;
        {host_cs_n_p1, host_ras_n_p1, host_cas_n_p1, host_we_n_p1} = c1;
        host_bank_p0 = b0; host_address_p0 = a0;
        host_bank_p1 = b1; host_address_p1 = a1;
    endtask

    task automatic do_reset(input string name);
        sys_rst = 1'b1;
        ref_ack = 1'b0;
        host_drive(C_NOP, 2'd0, 13'h0, C_NOP, 2'd0, 13'h0);
        step();
        cyc = 0;
        check(name, snap(), ew(pw(1'b0, C_DES, 2'd0, 13'h0), pw(1'b0, C_DES, 2'd0, 13'h0), 4'b0000));
        sys_rst = 1'b0;
    endtask

    task automatic run_init(input int upto);
        for (int k = 1; k <= upto; k++) begin
            step();
            check($sformatf("init[%0d]", k), snap(), init_exp(k));
        end
    endtask

    task automatic wait_req(input string name, input int exp_cyc);
        int n;
        n = 0;
        while (ref_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(name, 48'(cyc), 48'(exp_cyc));
    endtask

    logic [19:0] nopw, prew, arefw;
    logic [47:0] ref_seq[7];
    int          bad_window;

    initial begin
        nopw  = pw(1'b1, C_NOP, 2'd0, 13'h0);
        prew  = pw(1'b1, C_PRE, 2'd0, 13'h400);
        arefw = pw(1'b1, C_AREF, 2'd0, 13'h0);

        init_tab[0] = '{11, C_PRE, 2'd0, 13'h400};
        init_tab[1] = '{13, C_MRS, 2'd1, 13'h000};
        init_tab[2] = '{15, C_MRS, 2'd0, 13'h122};
        init_tab[3] = '{17, C_PRE, 2'd0, 13'h400};
        init_tab[4] = '{19, C_AREF, 2'd0, 13'h000};
        init_tab[5] = '{23, C_AREF, 2'd0, 13'h000};
        init_tab[6] = '{27, C_MRS, 2'd0, 13'h022};

        pt_tab[0] = '{4'b0011, 2'd2, 13'h01AB, 4'b0101, 2'd2, 13'h0010,
                      ew(pw(1'b1, 4'b0011, 2'd2, 13'h01AB), pw(1'b1, 4'b0101, 2'd2, 13'h0010), 4'b1010)};
        pt_tab[1] = '{4'b0100, 2'd1, 13'h0020, 4'b0111, 2'd0, 13'h0000,
                      ew(pw(1'b1, 4'b0100, 2'd1, 13'h0020), pw(1'b1, 4'b0111, 2'd0, 13'h0000), 4'b1010)};
        pt_tab[2] = '{4'b0010, 2'd3, 13'h0000, 4'b1111, 2'd0, 13'h1FFF,
                      ew(pw(1'b1, 4'b0010, 2'd3, 13'h0000), pw(1'b1, 4'b1111, 2'd0, 13'h1FFF), 4'b1010)};
        pt_tab[3] = '{4'b0111, 2'd1, 13'h1555, 4'b0011, 2'd0, 13'h0ABC,
                      ew(pw(1'b1, 4'b0111, 2'd1, 13'h1555), pw(1'b1, 4'b0011, 2'd0, 13'h0ABC), 4'b1010)};

        // Cycles 77..83 of the first refresh; host keeps driving WRITE/READ throughout.
        ref_seq[0] = ew(nopw,  nopw, 4'b0010);
        ref_seq[1] = ew(arefw, nopw, 4'b0010);
        ref_seq[2] = ew(nopw,  nopw, 4'b0010);
        ref_seq[3] = ew(nopw,  nopw, 4'b0010);
        ref_seq[4] = ew(nopw,  nopw, 4'b0010);
        ref_seq[5] = ew(nopw,  nopw, 4'b1010);
        ref_seq[6] = ew(pw(1'b1, 4'b0100, 2'd1, 13'h0055), pw(1'b1, 4'b0101, 2'd1, 13'h0066), 4'b1010);

        do_reset("reset_initial");
        run_init(33);

        for (int i = 0; i < 4; i++) begin
            host_drive(pt_tab[i].c0, pt_tab[i].b0, pt_tab[i].a0, pt_tab[i].c1, pt_tab[i].b1, pt_tab[i].a1);
            step();
            check($sformatf("pass[%0d]", i), snap(), pt_tab[i].exp);
        end
        host_drive(C_NOP, 2'd0, 13'h0, C_NOP, 2'd0, 13'h0);

        ref_ack = 1'b1;
        step();
        check("ack_no_req", snap(), ew(nopw, nopw, 4'b1010));
        ref_ack = 1'b0;
        step();
        check("after_ack_no_req", snap(), ew(nopw, nopw, 4'b1010));

        wait_req("ref_req_1", 72);
        for (int i = 0; i < 3; i++) begin
            step();
            check("req_held", snap(), ew(nopw, nopw, 4'b1110));
        end
        ref_ack = 1'b1;
        host_drive(4'b0100, 2'd1, 13'h0055, 4'b0101, 2'd1, 13'h0066);
        step();
        check("ref1_pre", snap(), ew(prew, nopw, 4'b0010));
        ref_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check($sformatf("ref1_seq[%0d]", i), snap(), ref_seq[i]);
        end
        host_drive(C_NOP, 2'd0, 13'h0, C_NOP, 2'd0, 13'h0);

        wait_req("ref_req_2", 112);
        run_to(151);
        check("missed_before", snap(), ew(nopw, nopw, 4'b1110));
        step();
        check("missed_set", snap(), ew(nopw, nopw, 4'b1111));
        run_to(155);
        check("missed_sticky", snap(), ew(nopw, nopw, 4'b1111));
        ref_ack = 1'b1;
        step();
        check("ref2_pre", snap(), ew(prew, nopw, 4'b0011));
        ref_ack = 1'b0;
        run_to(158);
        check("ref2_aref", snap(), ew(arefw, nopw, 4'b0011));
        run_to(162);
        check("ref2_back", snap(), ew(nopw, nopw, 4'b1011));
        bad_window = 0;
        while (cyc < 185) begin
            step();
            if (host_grant !== 1'b1 || ref_req !== 1'b0) bad_window++;
        end
        check("single_refresh", 48'(bad_window), 48'(0));

        wait_req("ref_req_3", 192);
        ref_ack = 1'b1;
        step();
        check("ref3_pre", snap(), ew(prew, nopw, 4'b0011));
        ref_ack = 1'b0;
        run_to(195);
        check("ref3_aref", snap(), ew(arefw, nopw, 4'b0011));
        step();
        do_reset("reset_in_ref_aref");
        run_init(24);
        do_reset("reset_in_aref2");
        run_init(33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
